mmio_uart: RTL and testbench

Memory-mapped UART peripheral on the RCPU data bus, directly downstream of the CPU's `memAddr`/`memWrite`/`memWE` port. It answers the 16-word I/O window at 0xD000–0xD00F, decoded externally into `sel`. It serialises CPU-written bytes onto `tx` as 8N1 frames through a TX FIFO. It deserialises `rx` frames into an RX FIFO that the CPU reads back.

---
 rtl/mmio_uart.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_mmio_uart.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART: TX/RX FIFOs, programmable bit divisor, sticky error flags
// and a registered level interrupt, living in a 16-word bus window.

module mmio_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rptr_q];

  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    wptr_d  = do_push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d  = do_pop  ? rptr_q + PTR_ONE : rptr_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_ONE;
    else if (do_pop && !do_push) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end
endmodule

module mmio_uart #(
  parameter int FIFO_DEPTH = 4,
  parameter int RESET_DIV  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [15:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [15:0] rdata,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic        rd, wr;
  logic [15:0] div_q, div_d, rdata_q, rdata_d, status;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        ovr_q, ovr_d, fe_q, fe_d, irq_q, irq_d, tx_done;

  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_dout;
  logic       rx_push, rx_pop, rx_full, rx_empty, rx_ovr_set, rx_fe_set;
  logic [7:0] rx_dout;

  state_e      tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic        tx_q, tx_d, tx_bit_end, rx_bit_end, rx_half_end;
  logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;

  mmio_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .din(wdata[7:0]), .pop(tx_pop),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  mmio_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .din(rx_sh_q), .pop(rx_pop),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  assign rd      = sel & re;
  assign wr      = sel & we;
  assign tx_done = tx_empty & (tx_state_q == S_IDLE);
  assign status  = {11'h000, fe_q, ovr_q, ~rx_empty, tx_done, tx_full};
  assign rdata   = rdata_q;
  assign tx      = tx_q;
  assign irq     = irq_q;

  // Bus side: register writes, registered reads, sticky flags and irq.
  always_comb begin
    div_d   = div_q;
    ctrl_d  = ctrl_q;
    rdata_d = rdata_q;
    ovr_d   = ovr_q;
    fe_d    = fe_q;
    tx_push = 1'b0;
    rx_pop  = 1'b0;
    if (wr) begin
      case (addr)
        4'd0:    tx_push = 1'b1;
        4'd2:    div_d   = (wdata < 16'd2) ? 16'd2 : wdata;
        4'd3:    ctrl_d  = wdata[1:0];
        default: ;
      endcase
    end
    if (rd) begin
      case (addr)
        4'd0: begin
          rdata_d = rx_empty ? 16'h0000 : {8'h00, rx_dout};
          rx_pop  = ~rx_empty;
        end
        4'd1: begin
          rdata_d = status;
          ovr_d   = 1'b0;
          fe_d    = 1'b0;
        end
        4'd2:    rdata_d = div_q;
        4'd3:    rdata_d = {14'h0000, ctrl_q};
        default: rdata_d = 16'h0000;
      endcase
    end
    // A new error in the same cycle as a STATUS read stays visible for the next read.
    if (rx_ovr_set) ovr_d = 1'b1;
    if (rx_fe_set)  fe_d  = 1'b1;
    irq_d = (ctrl_q[0] & tx_done) | (ctrl_q[1] & ~rx_empty);
  end

  // tx is registered off the current state, so it trails the state by one clock.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_div_d   = tx_div_q;
    tx_pop     = 1'b0;
    tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);
    case (tx_state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_dout;
          tx_div_d   = div_q;
          tx_cnt_d   = '0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      end
      S_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      end
      S_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_dout;
            tx_div_d   = div_q;
            tx_state_d = S_START;
          end else tx_state_d = S_IDLE;
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      end
      default: tx_state_d = S_IDLE;
    endcase
    tx_d = (tx_state_q == S_START) ? 1'b0 :
           (tx_state_q == S_DATA)  ? tx_sh_q[0] : 1'b1;
  end

  always_comb begin
    rx_s1_d     = rx;
    rx_s2_d     = rx_s1_q;
    rx_s3_d     = rx_s2_q;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_div_d    = rx_div_q;
    rx_push     = 1'b0;
    rx_ovr_set  = 1'b0;
    rx_fe_set   = 1'b0;
    rx_bit_end  = (rx_cnt_q == rx_div_q - 16'd1);
    rx_half_end = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);
    case (rx_state_q)
      S_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_div_d   = div_q;
          rx_cnt_d   = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_half_end) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else rx_cnt_d = rx_cnt_q + 16'd1;
      end
      S_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q + 16'd1;
      end
      S_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          if (!rx_s2_q)     rx_fe_set  = 1'b1;
          else if (rx_full) rx_ovr_set = 1'b1;
          else              rx_push    = 1'b1;
        end else rx_cnt_d = rx_cnt_q + 16'd1;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q      <= 16'(RESET_DIV);
      ctrl_q     <= '0;
      rdata_q    <= '0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      irq_q      <= 1'b0;
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_div_q   <= 16'(RESET_DIV);
      tx_q       <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_div_q   <= 16'(RESET_DIV);
    end else begin
      div_q      <= div_d;
      ctrl_q     <= ctrl_d;
      rdata_q    <= rdata_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
      irq_q      <= irq_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_div_q   <= tx_div_d;
      tx_q       <= tx_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_s3_q    <= rx_s3_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_div_q   <= rx_div_d;
    end
  end
endmodule

// File: tb/tb_mmio_uart.sv
// Scoreboarded bench for mmio_uart: a serial monitor decodes tx frames against a queue
// of expected bytes, and DATA reads are checked against a queue of expected RX bytes.
module tb_mmio_uart;
  localparam int BDIV = 4;

  logic        clk = 1'b0;
  logic        rst, sel, we, re, tx, rx, irq;
  logic [3:0]  addr;
  logic [15:0] wdata, rdata;
  logic        loop_en, rx_drv, mon_en;
  int          cyc = 0, n_chk = 0, n_pass = 0, wr_edge = 0, tx_frames = 0;
  logic [7:0]  tx_exp[$], rx_exp[$];
  int          tx_starts[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rx = loop_en ? tx : rx_drv;

  mmio_uart #(.FIFO_DEPTH(4), .RESET_DIV(16)) dut (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .tx(tx), .rx(rx), .irq(irq)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk); sel = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdata = d;
    @(posedge clk); #1; wr_edge = cyc;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
    @(negedge clk); sel = 1'b1; re = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1; d = rdata;
  endtask

  task automatic bus_idle();
    @(negedge clk); sel = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
    bus_write(a, d); bus_idle();
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d); bus_idle();
    chk(tag, d, exp);
  endtask

  task automatic rd_data();
    logic [15:0] d;
    bus_read(4'd0, d); bus_idle();
    if (rx_exp.size() > 0) chk("rx_byte", d, {8'h00, rx_exp.pop_front()});
    else                   chk("rx_empty_read", d, 16'h0000);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    logic [9:0] bits;
    bits = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rx_drv = bits[i];
      repeat (BDIV - 1) @(negedge clk);
    end
    @(negedge clk); rx_drv = 1'b1;
  endtask

  // Serial monitor: samples mid-bit and scores each decoded frame against tx_exp.
  initial begin
    logic       prev, st, sp;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (prev === 1'b1 && tx === 1'b0 && rst === 1'b1) begin
        tx_starts.push_back(cyc);
        repeat (BDIV / 2) @(posedge clk);
        #1; st = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (BDIV) @(posedge clk);
          #1; b[i] = tx;
        end
        repeat (BDIV) @(posedge clk);
        #1; sp = tx;
        if (mon_en) begin
          tx_frames++;
          chk("tx_start_bit", 16'(st), 16'h0000);
          chk("tx_stop_bit", 16'(sp), 16'h0001);
          if (tx_exp.size() > 0) chk("tx_byte", {8'h00, b}, {8'h00, tx_exp.pop_front()});
        end
      end
      prev = tx;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [7:0]  ob [5];
    logic        expb, hit;
    int          t0;

    rst = 1'b0; sel = 1'b1; we = 1'b1; re = 1'b0; addr = 4'd0; wdata = 16'hBEEF;
    loop_en = 1'b0; rx_drv = 1'b1; mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 16'(tx), 16'h0001);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_irq", 16'(irq), 16'h0000);
    @(negedge clk); rst = 1'b1; sel = 1'b0; we = 1'b0;

    rd_chk("rst_status", 4'd1, 16'h0002);
    rd_chk("rst_div", 4'd2, 16'd16);
    rd_chk("rst_ctrl", 4'd3, 16'h0000);
    wr_reg(4'd5, 16'hFFFF);
    rd_chk("unmapped", 4'd5, 16'h0000);
    rd_data();

    wr_reg(4'd2, 16'd1);  rd_chk("div_clamp1", 4'd2, 16'd2);
    wr_reg(4'd2, 16'd0);  rd_chk("div_clamp0", 4'd2, 16'd2);
    wr_reg(4'd2, 16'd3);  rd_chk("div_3", 4'd2, 16'd3);
    wr_reg(4'd2, 16'd4);  rd_chk("div_4", 4'd2, 16'd4);

    // tx_done interrupt, one clock after enable
    bus_write(4'd3, 16'h0001);
    chk("irq_before", 16'(irq), 16'h0000);
    bus_idle();
    @(posedge clk); #1;
    chk("irq_tx_done", 16'(irq), 16'h0001);
    rd_chk("ctrl_rd", 4'd3, 16'h0001);
    wr_reg(4'd3, 16'h0000);

    // single frame, exact waveform
    tx_exp.push_back(8'hA5);
    bus_write(4'd0, 16'h00A5);
    bus_idle();
    for (int k = 1; k <= 41; k++) begin
      @(posedge clk); #1;
      if (k >= 2 && k <= 5)       expb = 1'b0;
      else if (k >= 6 && k <= 37) expb = ob_bit(8'hA5, (k - 6) / 4);
      else                        expb = 1'b1;
      chk($sformatf("tx_wave_k%0d", k), 16'(tx), 16'(expb));
    end
    rd_chk("tx_done_n42", 4'd1, 16'h0002);

    // FIFO full: 6 back-to-back writes, 6th dropped, 5 contiguous frames
    repeat (5) @(negedge clk);
    tx_starts.delete();
    for (int i = 0; i < 5; i++) tx_exp.push_back(8'(i + 1));
    for (int i = 0; i < 6; i++) bus_write(4'd0, 16'(i + 1));
    rd_chk("tx_full", 4'd1, 16'h0001);
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      bus_read(4'd1, d);
      hit = d[1];
    end
    bus_idle();
    chk("tx_drain", 16'(hit), 16'h0001);
    repeat (4) @(negedge clk);
    chk("tx_nstarts", 16'(tx_starts.size()), 16'd5);
    for (int i = 1; i < tx_starts.size(); i++)
      chk("tx_gap", 16'(tx_starts[i] - tx_starts[i-1]), 16'(10 * BDIV));
    chk("tx_sb_left", 16'(tx_exp.size()), 16'd0);

    // loopback with rx interrupt
    @(negedge clk); loop_en = 1'b1;
    wr_reg(4'd3, 16'h0002);
    tx_exp.push_back(8'h3C);
    rx_exp.push_back(8'h3C);
    bus_write(4'd0, 16'h003C);
    bus_idle();
    hit = 1'b0; t0 = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk); #1;
      if (irq) begin hit = 1'b1; t0 = cyc; end
    end
    chk("rx_irq_seen", 16'(hit), 16'h0001);
    chk("rx_irq_latency", 16'(t0 - wr_edge), 16'd44);
    rd_chk("rx_status", 4'd1, 16'h0006);
    bus_read(4'd0, d);
    if (rx_exp.size() > 0) chk("rx_loop_byte", d, {8'h00, rx_exp.pop_front()});
    else                   chk("rx_loop_sb", 16'(rx_exp.size()), 16'd1);
    chk("irq_at_pop", 16'(irq), 16'h0001);
    bus_idle();
    @(posedge clk); #1;
    chk("irq_after_pop", 16'(irq), 16'h0000);
    wr_reg(4'd3, 16'h0000);
    @(negedge clk); loop_en = 1'b0;

    // framing error
    send_rx(8'h55, 1'b0);
    repeat (10) @(negedge clk);
    rd_chk("fe_status", 4'd1, 16'h0012);
    rd_chk("fe_cleared", 4'd1, 16'h0002);

    // overrun: 5 frames into a 4-deep FIFO
    ob[0] = 8'h11; ob[1] = 8'h22; ob[2] = 8'h33; ob[3] = 8'h44; ob[4] = 8'h55;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) rx_exp.push_back(ob[i]);
      send_rx(ob[i], 1'b1);
      repeat (3) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    rd_chk("ovr_status", 4'd1, 16'h000E);
    for (int i = 0; i < 4; i++) rd_data();
    rd_chk("ovr_cleared", 4'd1, 16'h0002);
    rd_data();

    // one-clock glitch is a false start
    @(negedge clk); rx_drv = 1'b0;
    @(negedge clk); rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    rd_chk("false_start", 4'd1, 16'h0002);

    // reset halfway through a frame
    mon_en = 1'b0;
    wr_reg(4'd0, 16'h0077);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_tx", 16'(tx), 16'h0001);
    chk("midrst_rdata", rdata, 16'h0000);
    @(negedge clk); rst = 1'b1;
    rd_chk("midrst_status", 4'd1, 16'h0002);
    rd_chk("midrst_div", 4'd2, 16'd16);
    repeat (60) @(negedge clk);
    mon_en = 1'b1;

    chk("tx_frames", 16'(tx_frames), 16'd7);
    chk("tx_sb_final", 16'(tx_exp.size()), 16'd0);
    chk("rx_sb_final", 16'(rx_exp.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  function automatic logic ob_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction
endmodule
